apb_adc_scan: RTL and testbench

- Parametrised successor to the single-channel APB ADC capture port. Scans up to NCH ADC channels in round-robin order, paced by a programmable period timer, and buffers tagged samples in a DEPTH-entry FIFO that software drains over APB.
- Adds continuous and single-scan modes, FIFO status with sticky overflow and overrun flags, and PSLVERR on unmapped addresses.
- Sits between the APB peripheral bus and the ADC front-end. It also drives adc2tmu_en to the TMU.

---
 rtl/apb_adc_scan_pkg.sv | 32 +++
 rtl/apb_adc_sfifo.sv | 60 ++++++
 rtl/apb_adc_scan.sv | 206 ++++++++++++++++++++
 tb/tb_apb_adc_scan.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_adc_scan_pkg.sv
// apb_adc_scan_pkg: shared register offsets, field positions, scan states and
// the FIFO entry width helper for the APB ADC scan controller.
package apb_adc_scan_pkg;

    localparam logic [11:0] A_CTRL   = 12'h000;
    localparam logic [11:0] A_DIV    = 12'h004;
    localparam logic [11:0] A_STATUS = 12'h008;
    localparam logic [11:0] A_DATA   = 12'h00C;

    localparam int C_EN    = 0;
    localparam int C_TMU   = 1;
    localparam int C_MODE  = 2;
    localparam int C_FLUSH = 3;
    localparam int C_MASK  = 16;

    localparam int S_EMPTY = 0;
    localparam int S_FULL  = 1;
    localparam int S_OVF   = 2;
    localparam int S_OVR   = 3;
    localparam int S_LVL   = 8;

    localparam int D_VALID = 31;
    localparam int D_CH    = 24;

    typedef enum logic [1:0] {IDLE, WAIT_TICK, START, CONV} scan_state_t;

    // FIFO entry = 4-bit channel tag above the sample.
    function automatic int entry_w(input int adc_w);
        return 4 + adc_w;
    endfunction

endpackage

// File: rtl/apb_adc_sfifo.sv
// apb_adc_sfifo: synchronous FIFO with flush, level and combinational head.
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_push, i_data    write request and entry
//   i_pop             read request (ignored while empty)
//   i_flush           empty the FIFO; wins over a same-cycle push/pop
//   o_head            oldest entry
//   o_empty, o_full   status
//   o_level           entries held (0..DEPTH)
//   o_overflow        pulse: push dropped because full with no pop
module apb_adc_sfifo #(
    parameter int W     = 16,
    parameter int DEPTH = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [W-1:0]               i_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [W-1:0]               o_head,
    output logic                       o_empty,
    output logic                       o_full,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_overflow
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]  r_wptr, r_rptr;
    logic [W-1:0] r_mem [DEPTH];
    logic         w_pop, w_push;

    assign o_level    = r_wptr - r_rptr;
    assign o_empty    = r_wptr == r_rptr;
    assign o_full     = o_level == (AW+1)'(DEPTH);
    assign o_head     = r_mem[r_rptr[AW-1:0]];
    assign w_pop      = i_pop & ~o_empty & ~i_flush;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign w_push     = i_push & ~i_flush & (~o_full | w_pop);
    assign o_overflow = i_push & ~i_flush & o_full & ~w_pop;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/apb_adc_scan.sv
// apb_adc_scan: APB-controlled round-robin ADC channel scanner with a tagged
// sample FIFO.
//   PCLK, PRESET                 clock, asynchronous active-high reset
//   PSEL..PWDATA, PRDATA,
//   PREADY, PSLVERR              APB slave (writes commit in setup phase)
//   ADC_DATA, ADC_VALID          conversion result and its one-cycle strobe
//   adc_start, adc_ch            conversion request pulse and channel
//   sample_enable, adc2tmu_en    CTRL[0] and CTRL[1]
module apb_adc_scan
    import apb_adc_scan_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int ADC_W = 12,
    parameter int DEPTH = 16,
    parameter int DIV_W = 16
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             PSEL,
    input  logic             PENABLE,
    input  logic             PWRITE,
    input  logic [11:0]      PADDR,
    input  logic [31:0]      PWDATA,
    output logic [31:0]      PRDATA,
    output logic             PREADY,
    output logic             PSLVERR,
    input  logic [ADC_W-1:0] ADC_DATA,
    input  logic             ADC_VALID,
    output logic             adc_start,
    output logic [3:0]       adc_ch,
    output logic             sample_enable,
    output logic             adc2tmu_en
);

    localparam int EW = entry_w(ADC_W);
    localparam int AW = $clog2(DEPTH);

    logic             r_en, r_tmu, r_mode, r_ovf, r_ovr;
    logic [NCH-1:0]   r_mask;
    logic [DIV_W-1:0] r_div, r_cnt;
    logic [3:0]       r_ch;
    scan_state_t      r_state;

    logic             w_setup_wr, w_rd_acc, w_mapped;
    logic             w_wr_ctrl, w_wr_div, w_wr_stat;
    logic             w_flush, w_pop, w_push, w_single_done;
    logic             w_run, w_tick;
    logic [DIV_W-1:0] w_reload;
    logic [3:0]       w_ch_nxt, w_lo_ch, w_hi_ch;
    logic             w_hi_ok;
    scan_state_t      w_state_nxt;
    logic [EW-1:0]    w_head;
    logic             w_empty, w_full, w_fifo_ovf;
    logic [AW:0]      w_level;
    logic             w_unused;

    assign w_setup_wr = PSEL & ~PENABLE & PWRITE;
    assign w_rd_acc   = PSEL & PENABLE & ~PWRITE;
    assign w_mapped   = (PADDR == A_CTRL) | (PADDR == A_DIV) |
                        (PADDR == A_STATUS) | (PADDR == A_DATA);
    assign w_wr_ctrl  = w_setup_wr & (PADDR == A_CTRL);
    assign w_wr_div   = w_setup_wr & (PADDR == A_DIV);
    assign w_wr_stat  = w_setup_wr & (PADDR == A_STATUS);
    assign w_flush    = w_wr_ctrl & PWDATA[C_FLUSH];
    assign w_pop      = w_rd_acc & (PADDR == A_DATA);
    assign PREADY     = 1'b1;
    assign PSLVERR    = PSEL & PENABLE & ~w_mapped;
    assign w_unused   = ^PWDATA;

    assign sample_enable = r_en;
    assign adc2tmu_en    = r_tmu;
    assign adc_ch        = r_ch;
    assign adc_start     = r_state == START;

    // Period timer: a DIV of 0 reloads to 0 and so ticks every cycle, like DIV=1.
    assign w_run    = r_en & (|r_mask);
    assign w_tick   = w_run & (r_cnt == '0);
    assign w_reload = (r_div == '0) ? '0 : r_div - DIV_W'(1);

    // Lowest set mask bit, and lowest set bit above the current channel.
    always_comb begin
        w_lo_ch = '0;
        w_hi_ch = '0;
        w_hi_ok = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (r_mask[i]) w_lo_ch = 4'(i);
            if (r_mask[i] && 4'(i) > r_ch) begin
                w_hi_ch = 4'(i);
                w_hi_ok = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ch_nxt      = r_ch;
        w_push        = 1'b0;
        w_single_done = 1'b0;
        case (r_state)
            IDLE:      w_state_nxt = w_run ? WAIT_TICK : IDLE;
            WAIT_TICK: begin
                if (!w_run) begin
                    w_state_nxt = IDLE;
                end else if (w_tick) begin
                    w_ch_nxt    = w_lo_ch;
                    w_state_nxt = START;
                end
            end
            START:     w_state_nxt = CONV;
            CONV: begin
                // A started conversion always completes and is pushed,
                // even if scanning was disabled meanwhile.
                if (ADC_VALID) begin
                    w_push = 1'b1;
                    if (!r_en) begin
                        w_state_nxt = IDLE;
                    end else if (w_hi_ok) begin
                        w_ch_nxt    = w_hi_ch;
                        w_state_nxt = START;
                    end else if (r_mode) begin
                        w_single_done = 1'b1;
                        w_state_nxt   = IDLE;
                    end else begin
                        w_state_nxt = WAIT_TICK;
                    end
                end
            end
            default:   w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state <= IDLE;
            r_ch    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ch    <= w_ch_nxt;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_en   <= 1'b0;
            r_tmu  <= 1'b0;
            r_mode <= 1'b0;
            r_mask <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_en   <= PWDATA[C_EN];
                r_tmu  <= PWDATA[C_TMU];
                r_mode <= PWDATA[C_MODE];
                r_mask <= PWDATA[C_MASK +: NCH];
            end else if (w_single_done) begin
                r_en <= 1'b0;
            end
            if (w_wr_div) r_div <= PWDATA[DIV_W-1:0];
            r_cnt <= !w_run ? '0 : (w_tick ? w_reload : r_cnt - DIV_W'(1));
            // Sticky flags: a new event wins over a same-cycle clear.
            r_ovf <= w_fifo_ovf | (r_ovf & ~(w_wr_stat & PWDATA[S_OVF]));
            r_ovr <= (w_tick & (r_state == START || r_state == CONV)) |
                     (r_ovr & ~(w_wr_stat & PWDATA[S_OVR]));
        end
    end

    apb_adc_sfifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .i_clk      (PCLK),
        .i_rst      (PRESET),
        .i_push     (w_push),
        .i_data     ({r_ch, ADC_DATA}),
        .i_pop      (w_pop),
        .i_flush    (w_flush),
        .o_head     (w_head),
        .o_empty    (w_empty),
        .o_full     (w_full),
        .o_level    (w_level),
        .o_overflow (w_fifo_ovf)
    );

    always_comb begin
        PRDATA = '0;
        if (PADDR == A_CTRL) begin
            PRDATA[C_EN]           = r_en;
            PRDATA[C_TMU]          = r_tmu;
            PRDATA[C_MODE]         = r_mode;
            PRDATA[C_MASK +: NCH]  = r_mask;
        end else if (PADDR == A_DIV) begin
            PRDATA[DIV_W-1:0]      = r_div;
        end else if (PADDR == A_STATUS) begin
            PRDATA[S_EMPTY]        = w_empty;
            PRDATA[S_FULL]         = w_full;
            PRDATA[S_OVF]          = r_ovf;
            PRDATA[S_OVR]          = r_ovr;
            PRDATA[S_LVL +: 8]     = 8'(w_level);
        end else if (PADDR == A_DATA && !w_empty) begin
            PRDATA[D_VALID]        = 1'b1;
            PRDATA[D_CH +: 4]      = w_head[ADC_W +: 4];
            PRDATA[ADC_W-1:0]      = w_head[ADC_W-1:0];
        end
    end

endmodule

// File: tb/tb_apb_adc_scan.sv
// tb_apb_adc_scan: scoreboard bench for apb_adc_scan. Every APB access queues
// its expected PRDATA/PSLVERR; a negedge monitor pops and compares on each
// access phase. An ADC model answers adc_start with 0x100+ch after `lat`
// cycles.
module tb_apb_adc_scan;

    localparam logic [11:0] CTRL = 12'h000, DIV = 12'h004, STAT = 12'h008, DATA = 12'h00C;

    logic        PCLK = 1'b0, PRESET = 1'b1;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [11:0] PADDR = '0;
    logic [31:0] PWDATA = '0, PRDATA;
    logic        PREADY, PSLVERR;
    logic [11:0] ADC_DATA = '0;
    logic        ADC_VALID = 1'b0;
    logic        adc_start, sample_enable, adc2tmu_en;
    logic [3:0]  adc_ch;

    typedef struct packed {
        logic [31:0] exp;
        logic [31:0] msk;
        logic        err;
        logic [11:0] addr;
    } sb_t;

    sb_t  sb[$];
    sb_t  mon_e;
    int   errors = 0, checks = 0, cyc = 0;
    int   lat = 3, pend = 0;
    bit   auto_adc = 1'b1;
    logic [3:0] pch = '0;
    int   t0, t1, t2, t3, t4, s;

    apb_adc_scan dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .ADC_DATA(ADC_DATA),
        .ADC_VALID(ADC_VALID), .adc_start(adc_start), .adc_ch(adc_ch),
        .sample_enable(sample_enable), .adc2tmu_en(adc2tmu_en)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    // ADC front-end model; it keeps counting through reset so a late strobe can arrive.
    initial forever begin
        @(posedge PCLK);
        #1;
        if (auto_adc) begin
            ADC_VALID = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    ADC_VALID = 1'b1;
                    ADC_DATA  = 12'h100 + 12'(pch);
                end
            end
            if (adc_start) begin
                pend = lat;
                pch  = adc_ch;
            end
        end
    end

    always @(negedge PCLK) begin
        if (PSEL && PENABLE) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL apb_unexpected addr=%h", PADDR);
            end else begin
                mon_e = sb.pop_front();
                if (((PRDATA & mon_e.msk) !== (mon_e.exp & mon_e.msk)) || PSLVERR !== mon_e.err) begin
                    errors++;
                    $display("FAIL apb addr=%h got data=%h err=%b want data=%h err=%b",
                             mon_e.addr, PRDATA, PSLVERR, mon_e.exp, mon_e.err);
                end
            end
        end
    end

    task automatic apb(input logic wr, input logic [11:0] a, input logic [31:0] d,
                       input logic [31:0] exp, input logic [31:0] msk, input logic err,
                       input bit pulse);
        sb.push_back({exp, msk, err, a});
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
        @(posedge PCLK);
        #1 PENABLE = 1'b1;
        if (pulse) begin
            ADC_VALID = 1'b1;
            ADC_DATA  = 12'h1AB;
        end
        @(posedge PCLK);
        #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        if (pulse) ADC_VALID = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        apb(1'b1, a, d, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp);
        apb(1'b0, a, 32'h0, exp, 32'hFFFF_FFFF, 1'b0, 1'b0);
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", n, act, exp);
        end
    endtask

    task automatic wait_start(output int c);
        c = -1;
        for (int k = 0; k < 60 && c < 0; k++) begin
            @(posedge PCLK);
            #1;
            if (adc_start) c = cyc;
        end
        if (c < 0) begin
            checks++;
            errors++;
            $display("FAIL adc_start_timeout got none want pulse");
        end
    endtask

    task automatic count_starts(input int n, output int k);
        k = 0;
        repeat (n) begin
            @(posedge PCLK);
            #1;
            if (adc_start) k++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset state
        idle(3);
        chk("rst_adc_start", 32'(adc_start), 0);
        chk("rst_sample_enable", 32'(sample_enable), 0);
        chk("rst_tmu", 32'(adc2tmu_en), 0);
        chk("rst_adc_ch", 32'(adc_ch), 0);
        PRESET = 1'b0;
        idle(1);
        rd(CTRL, 32'h0);
        rd(DIV, 32'h0);
        rd(STAT, 32'h1);
        rd(DATA, 32'h0);

        // 2: continuous scan, mask 1010, period 10
        wr(DIV, 32'd10);
        wr(CTRL, 32'h000A_000B);
        chk("t2_sample_enable", 32'(sample_enable), 1);
        chk("t2_tmu", 32'(adc2tmu_en), 1);
        rd(CTRL, 32'h000A_0003);
        rd(DIV, 32'd10);
        wait_start(t0);
        chk("t2_ch_first", 32'(adc_ch), 1);
        wait_start(t1);
        chk("t2_ch_second", 32'(adc_ch), 3);
        chk("t2_gap", 32'(t1 - t0), 4);
        wait_start(t2);
        chk("t2_ch_rescan", 32'(adc_ch), 1);
        chk("t2_period_a", 32'(t2 - t0), 10);
        wait_start(t3);
        wait_start(t4);
        chk("t2_period_b", 32'(t4 - t2), 10);
        wr(CTRL, 32'h0);
        count_starts(20, s);
        chk("t2_stopped", 32'(s), 0);
        rd(STAT, 32'h0000_0500);
        rd(DATA, 32'h8100_0101);
        rd(DATA, 32'h8300_0103);
        rd(DATA, 32'h8100_0101);
        rd(DATA, 32'h8300_0103);
        rd(DATA, 32'h8100_0101);
        rd(DATA, 32'h0);
        rd(STAT, 32'h1);

        // 3: single scan of channel 0
        wr(CTRL, 32'h0001_0005);
        wait_start(t0);
        chk("t3_ch", 32'(adc_ch), 0);
        count_starts(40, s);
        chk("t3_no_rescan", 32'(s), 0);
        chk("t3_enable_cleared", 32'(sample_enable), 0);
        rd(CTRL, 32'h0001_0004);
        rd(STAT, 32'h0000_0100);
        rd(DATA, 32'h8000_0100);
        rd(STAT, 32'h1);

        // 4: fill to overflow, clear flag, drain in order
        wr(CTRL, 32'h000A_0001);
        idle(140);
        wr(CTRL, 32'h0);
        idle(12);
        rd(STAT, 32'h0000_1006);
        wr(STAT, 32'h4);
        rd(STAT, 32'h0000_1002);
        for (int i = 0; i < 16; i++) rd(DATA, (i % 2) ? 32'h8300_0103 : 32'h8100_0101);
        rd(DATA, 32'h0);
        rd(STAT, 32'h1);

        // 5: DIV=1 overrun, pop+push while full, flush
        wr(DIV, 32'd1);
        lat = 5;
        wr(CTRL, 32'h000F_0001);
        idle(150);
        auto_adc = 1'b0;
        ADC_VALID = 1'b0;
        idle(10);
        rd(STAT, 32'h0000_100E);
        wr(STAT, 32'h4);
        rd(STAT, 32'h0000_100A);
        apb(1'b0, DATA, 32'h0, 32'h8000_0100, 32'hFFFF_FFFF, 1'b0, 1'b1);
        rd(STAT, 32'h0000_100A);
        rd(DATA, 32'h8100_0101);
        rd(STAT, 32'h0000_0F08);
        wr(CTRL, 32'h8);
        rd(STAT, 32'h9);
        wr(STAT, 32'h8);
        rd(STAT, 32'h1);

        // 6: reset mid-conversion, late strobe, unmapped access
        wr(CTRL, 32'h000F_0003);
        chk("t6_en_before", 32'(sample_enable), 1);
        chk("t6_tmu_before", 32'(adc2tmu_en), 1);
        #2 PRESET = 1'b1;
        #1;
        chk("t6_rst_enable", 32'(sample_enable), 0);
        chk("t6_rst_tmu", 32'(adc2tmu_en), 0);
        chk("t6_rst_start", 32'(adc_start), 0);
        chk("t6_rst_ch", 32'(adc_ch), 0);
        @(posedge PCLK);
        @(posedge PCLK);
        #1 PRESET = 1'b0;
        ADC_VALID = 1'b1;
        ADC_DATA  = 12'h155;
        @(posedge PCLK);
        #1 ADC_VALID = 1'b0;
        @(posedge PCLK);
        #1 ADC_VALID = 1'b1;
        @(posedge PCLK);
        #1 ADC_VALID = 1'b0;
        rd(STAT, 32'h1);
        rd(CTRL, 32'h0);
        rd(DIV, 32'h0);
        rd(DATA, 32'h0);
        apb(1'b0, 12'h040, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        apb(1'b1, 12'h040, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1, 1'b0);
        rd(CTRL, 32'h0);
        count_starts(10, s);
        chk("t6_no_start", 32'(s), 0);

        for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge PCLK);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_drain got %0d want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
